mem_transfer_sequencer: RTL and testbench

- Parametrised multi-byte load/store sequencer between a DATA_WIDTH-bit register-side word and the byte-wide system Memory.
- Generalises the DR byte-assembly path and the MuxC byte-select path into one block with programmable transfer size, auto-incrementing address, endianness and sign/zero extension.
- Sits between the control unit (Start/Done handshake) and the Memory ports (Address, Data, WR, CS, MemOut).

---
 rtl/mem_transfer_sequencer.sv | 171 +++++++++++++++++
 tb/tb_mem_transfer_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_transfer_sequencer.sv
// Multi-byte load/store sequencer between a DATA_WIDTH register word and byte-wide memory.
// Programmable size, auto-incrementing address, selectable endianness and sign/zero extension.
module mem_transfer_sequencer #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDR_WIDTH    = 16,
  parameter bit          LITTLE_ENDIAN = 1'b1,
  localparam int unsigned NUM_BYTES    = DATA_WIDTH / 8,
  localparam int unsigned SZ_W         = $clog2(NUM_BYTES)
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic                  Op,
  input  logic [SZ_W-1:0]       Size,
  input  logic                  SignExt,
  input  logic [ADDR_WIDTH-1:0] BaseAddr,
  input  logic [DATA_WIDTH-1:0] StoreData,
  output logic                  Busy,
  output logic                  Done,
  output logic [DATA_WIDTH-1:0] LoadData,
  output logic [ADDR_WIDTH-1:0] Mem_Address,
  output logic [7:0]            Mem_Data,
  output logic                  Mem_WR,
  output logic                  Mem_CS,
  input  logic [7:0]            MemOut
);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [SZ_W-1:0]       cnt_q, cnt_d, cnt_nx;
  logic                  op_q, op_d;
  logic [SZ_W-1:0]       size_q, size_d;
  logic                  sext_q, sext_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [DATA_WIDTH-1:0] sdata_q, sdata_d;
  logic [DATA_WIDTH-1:0] asm_q, asm_d;
  logic [DATA_WIDTH-1:0] load_d;
  logic                  busy_d, done_d, cs_d, wr_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [7:0]            wdata_d;

  // Word byte touched on a given beat; big-endian walks down from the top byte of the transfer
  function automatic logic [SZ_W-1:0] byte_idx(input logic [SZ_W-1:0] c, input logic [SZ_W-1:0] sz);
    return LITTLE_ENDIAN ? c : SZ_W'(sz - c);
  endfunction

  function automatic logic [7:0] sel_byte(input logic [DATA_WIDTH-1:0] d, input logic [SZ_W-1:0] idx);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < NUM_BYTES; i++)
      if (SZ_W'(i) == idx) r = d[i*8 +: 8];
    return r;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] put_byte(input logic [DATA_WIDTH-1:0] d,
                                                     input logic [SZ_W-1:0] idx, input logic [7:0] b);
    logic [DATA_WIDTH-1:0] r;
    r = d;
    for (int i = 0; i < NUM_BYTES; i++)
      if (SZ_W'(i) == idx) r[i*8 +: 8] = b;
    return r;
  endfunction

  // Bytes above the transfer size are filled from bit 7 of the top byte, or zeroed
  function automatic logic [DATA_WIDTH-1:0] extend(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [SZ_W-1:0] sz, input logic se);
    logic [DATA_WIDTH-1:0] r;
    logic                  fill;
    r    = a;
    fill = 1'b0;
    for (int i = 0; i < NUM_BYTES; i++)
      if (SZ_W'(i) == sz) fill = se & a[i*8 + 7];
    for (int i = 0; i < NUM_BYTES; i++)
      if (SZ_W'(i) > sz) r[i*8 +: 8] = {8{fill}};
    return r;
  endfunction

  // Next state, operand latches and next values of the registered memory/handshake outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    size_d  = size_q;
    sext_d  = sext_q;
    base_d  = base_q;
    sdata_d = sdata_q;
    asm_d   = asm_q;
    load_d  = LoadData;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    cs_d    = 1'b1;
    wr_d    = 1'b0;
    addr_d  = '0;
    wdata_d = 8'h00;
    cnt_nx  = cnt_q + SZ_W'(1);
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          op_d    = Op;
          size_d  = Size;
          sext_d  = SignExt;
          base_d  = BaseAddr;
          sdata_d = StoreData;
          cnt_d   = '0;
          asm_d   = '0;
          state_d = S_XFER;
          busy_d  = 1'b1;
          cs_d    = 1'b0;
          wr_d    = Op;
          addr_d  = BaseAddr;
          if (Op) wdata_d = sel_byte(StoreData, byte_idx(SZ_W'(0), Size));
        end
      end
      S_XFER: begin
        if (!op_q) asm_d = put_byte(asm_q, byte_idx(cnt_q, size_q), MemOut);
        cnt_d = cnt_nx;
        if (cnt_q == size_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          if (!op_q) load_d = extend(asm_d, size_q, sext_q);
        end else begin
          busy_d = 1'b1;
          cs_d   = 1'b0;
          wr_d   = op_q;
          addr_d = base_q + ADDR_WIDTH'(cnt_nx);
          if (op_q) wdata_d = sel_byte(sdata_q, byte_idx(cnt_nx, size_q));
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_q        <= 1'b0;
      size_q      <= '0;
      sext_q      <= 1'b0;
      base_q      <= '0;
      sdata_q     <= '0;
      asm_q       <= '0;
      LoadData    <= '0;
      Busy        <= 1'b0;
      Done        <= 1'b0;
      Mem_CS      <= 1'b1;
      Mem_WR      <= 1'b0;
      Mem_Address <= '0;
      Mem_Data    <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      size_q      <= size_d;
      sext_q      <= sext_d;
      base_q      <= base_d;
      sdata_q     <= sdata_d;
      asm_q       <= asm_d;
      LoadData    <= load_d;
      Busy        <= busy_d;
      Done        <= done_d;
      Mem_CS      <= cs_d;
      Mem_WR      <= wr_d;
      Mem_Address <= addr_d;
      Mem_Data    <= wdata_d;
    end
  end

endmodule

// File: tb/tb_mem_transfer_sequencer.sv
// Scoreboard bench for mem_transfer_sequencer: stimulus pushes expected writes/results,
// a monitor pops and compares them; a big-endian instance is checked directly.
module tb_mem_transfer_sequencer;

  logic        Clock, Reset;
  logic        Start, Op, SignExt;
  logic [1:0]  Size;
  logic [15:0] BaseAddr;
  logic [31:0] StoreData;
  logic        Busy, Done, Mem_WR, Mem_CS;
  logic [31:0] LoadData;
  logic [15:0] Mem_Address;
  logic [7:0]  Mem_Data, MemOut;

  logic        b_Start, b_Op, b_SignExt;
  logic [1:0]  b_Size;
  logic [15:0] b_BaseAddr;
  logic [31:0] b_StoreData;
  logic        b_Busy, b_Done, b_Mem_WR, b_Mem_CS;
  logic [31:0] b_LoadData;
  logic [15:0] b_Mem_Address;
  logic [7:0]  b_Mem_Data, b_MemOut;

  logic [7:0]  mem [0:65535];
  logic [23:0] exp_wr[$];
  logic [31:0] exp_done[$];
  logic [31:0] exp_ld;
  int          n_tests, n_fail;

  assign MemOut   = mem[Mem_Address];
  assign b_MemOut = mem[b_Mem_Address];

  mem_transfer_sequencer #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .LITTLE_ENDIAN(1'b1)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Op(Op), .Size(Size), .SignExt(SignExt),
    .BaseAddr(BaseAddr), .StoreData(StoreData), .Busy(Busy), .Done(Done), .LoadData(LoadData),
    .Mem_Address(Mem_Address), .Mem_Data(Mem_Data), .Mem_WR(Mem_WR), .Mem_CS(Mem_CS),
    .MemOut(MemOut));

  mem_transfer_sequencer #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .LITTLE_ENDIAN(1'b0)) dut_be (
    .Clock(Clock), .Reset(Reset), .Start(b_Start), .Op(b_Op), .Size(b_Size), .SignExt(b_SignExt),
    .BaseAddr(b_BaseAddr), .StoreData(b_StoreData), .Busy(b_Busy), .Done(b_Done),
    .LoadData(b_LoadData), .Mem_Address(b_Mem_Address), .Mem_Data(b_Mem_Data),
    .Mem_WR(b_Mem_WR), .Mem_CS(b_Mem_CS), .MemOut(b_MemOut));

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endfunction

  // Monitor: every write beat and every Done pulse must match the head of its queue
  initial begin
    logic [23:0] w;
    forever begin
      @(negedge Clock);
      if (Reset && !Mem_CS && Mem_WR) begin
        if (exp_wr.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_write: got addr=0x%0h data=0x%0h, required no write",
                   Mem_Address, Mem_Data);
        end else begin
          w = exp_wr.pop_front();
          chk("wr_addr", 32'(Mem_Address), 32'(w[23:8]));
          chk("wr_data", 32'(Mem_Data), 32'(w[7:0]));
        end
      end
      if (Done) begin
        if (exp_done.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: got Done=1, required no completion");
        end else begin
          chk("done_loaddata", LoadData, exp_done.pop_front());
        end
      end
    end
  end

  // Issue one transfer on the LE instance, then scramble operands after acceptance
  task automatic issue(input logic op, input logic [1:0] sz, input logic se, input logic [15:0] base,
                       input logic [31:0] sd, input int nwr, input bit push_done,
                       input logic [31:0] exp_res);
    @(negedge Clock);
    Op = op; Size = sz; SignExt = se; BaseAddr = base; StoreData = sd; Start = 1'b1;
    if (op) for (int k = 0; k < nwr; k++) exp_wr.push_back({16'(base + 16'(k)), sd[8*k +: 8]});
    if (!op) exp_ld = exp_res;
    if (push_done) exp_done.push_back(exp_ld);
    @(posedge Clock);
    #1;
    Start = 1'b0; Op = ~op; Size = ~sz; SignExt = ~se; BaseAddr = 16'h1234; StoreData = ~sd;
  endtask

  task automatic wait_done(input int exp_busy, input string nm);
    int busy_n;
    bit got;
    busy_n = 0;
    got    = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge Clock);
      if (Done) got = 1'b1;
      else if (Busy) busy_n++;
    end
    chk({nm, "_done_seen"}, 32'(got), 32'd1);
    chk({nm, "_busy_cycles"}, busy_n, exp_busy);
    chk({nm, "_busy_low_in_done"}, 32'(Busy), 32'd0);
    @(negedge Clock);
    chk({nm, "_done_single"}, 32'(Done), 32'd0);
  endtask

  // Big-endian instance: check every beat and the result directly
  task automatic b_run(input logic op, input logic [1:0] sz, input logic se, input logic [15:0] base,
                       input logic [31:0] sd, input logic [31:0] exp_res, input string nm);
    bit got;
    int k;
    logic [31:0] sh;
    @(negedge Clock);
    b_Op = op; b_Size = sz; b_SignExt = se; b_BaseAddr = base; b_StoreData = sd; b_Start = 1'b1;
    @(posedge Clock);
    #1;
    b_Start = 1'b0; b_StoreData = ~sd; b_BaseAddr = 16'h4321;
    got = 1'b0;
    k   = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge Clock);
      if (b_Done) got = 1'b1;
      else begin
        if (op) begin
          sh = sd >> (8 * (int'(sz) - k));
          chk({nm, "_wr_addr"}, 32'(b_Mem_Address), 32'(16'(base + 16'(k))));
          chk({nm, "_wr_data"}, 32'(b_Mem_Data), {24'h0, sh[7:0]});
        end
        k++;
      end
    end
    chk({nm, "_done_seen"}, 32'(got), 32'd1);
    chk({nm, "_beats"}, k, int'(sz) + 1);
    if (!op) chk(nm, b_LoadData, exp_res);
  endtask

  initial begin
    bit got;
    n_tests = 0; n_fail = 0; exp_ld = 32'h0;
    Start = 0; Op = 0; Size = 0; SignExt = 0; BaseAddr = 0; StoreData = 0;
    b_Start = 0; b_Op = 0; b_Size = 0; b_SignExt = 0; b_BaseAddr = 0; b_StoreData = 0;
    mem[16'h0010] = 8'h34; mem[16'h0011] = 8'h92;
    mem[16'h0020] = 8'h11; mem[16'h0021] = 8'h22; mem[16'h0022] = 8'h33; mem[16'h0023] = 8'h44;
    mem[16'h0030] = 8'h01; mem[16'h0031] = 8'h80; mem[16'h0032] = 8'hF0;
    mem[16'h0050] = 8'h80;
    Reset = 1'b1;
    #2 Reset = 1'b0;
    repeat (3) @(negedge Clock);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_loaddata", LoadData, 32'h0);
    chk("rst_cs", 32'(Mem_CS), 32'd1);
    chk("rst_wr", 32'(Mem_WR), 32'd0);
    chk("rst_addr", 32'(Mem_Address), 32'h0);
    chk("rst_data", 32'(Mem_Data), 32'h0);
    Reset = 1'b1;
    repeat (2) @(negedge Clock);

    issue(1'b1, 2'd3, 1'b0, 16'h00FE, 32'hA1B2C3D4, 4, 1'b1, 32'h0);
    wait_done(4, "st_word");
    issue(1'b0, 2'd1, 1'b1, 16'h0010, 32'h0, 0, 1'b1, 32'hFFFF9234);
    wait_done(2, "ld_half_s");
    issue(1'b0, 2'd1, 1'b0, 16'h0010, 32'h0, 0, 1'b1, 32'h00009234);
    wait_done(2, "ld_half_u");
    issue(1'b1, 2'd0, 1'b0, 16'h0040, 32'h00000077, 1, 1'b1, 32'h0);
    wait_done(1, "st_keeps_ld");
    issue(1'b0, 2'd2, 1'b1, 16'h0030, 32'h0, 0, 1'b1, 32'hFFF08001);
    wait_done(3, "ld_3b_s");
    issue(1'b0, 2'd2, 1'b0, 16'h0030, 32'h0, 0, 1'b1, 32'h00F08001);
    wait_done(3, "ld_3b_u");
    issue(1'b1, 2'd1, 1'b0, 16'hFFFF, 32'h00005A3C, 2, 1'b1, 32'h0);
    wait_done(2, "st_wrap");

    // Start pulses during XFER and DONE must not launch a transfer
    issue(1'b0, 2'd3, 1'b0, 16'h0020, 32'h0, 0, 1'b1, 32'h44332211);
    @(negedge Clock);
    Op = 1'b1; Size = 2'd3; BaseAddr = 16'h0500; StoreData = 32'hDEADBEEF; Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge Clock);
      got = Done;
    end
    chk("hs_done_seen", 32'(got), 32'd1);
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    chk("hs_start_in_done_ignored", 32'(Busy), 32'd0);
    repeat (3) @(negedge Clock);
    chk("hs_still_idle", 32'(Busy), 32'd0);

    // Start held high: second load begins one IDLE cycle after Done
    @(negedge Clock);
    Op = 1'b0; Size = 2'd3; SignExt = 1'b0; BaseAddr = 16'h0020; Start = 1'b1;
    exp_ld = 32'h44332211;
    exp_done.push_back(exp_ld);
    exp_done.push_back(exp_ld);
    wait_done(4, "hold_first");
    chk("hold_gap_idle", 32'(Busy), 32'd0);
    @(negedge Clock);
    chk("hold_second_start", 32'(Busy), 32'd1);
    Start = 1'b0;
    wait_done(3, "hold_second");

    // Reset right after the byte-1 write of a word store
    issue(1'b1, 2'd3, 1'b0, 16'h0300, 32'h01020304, 2, 1'b0, 32'h0);
    @(negedge Clock);
    @(negedge Clock);
    @(posedge Clock);
    #1 Reset = 1'b0;
    #1;
    chk("midrst_cs", 32'(Mem_CS), 32'd1);
    chk("midrst_wr", 32'(Mem_WR), 32'd0);
    chk("midrst_busy", 32'(Busy), 32'd0);
    chk("midrst_loaddata", LoadData, 32'h0);
    chk("midrst_addr", 32'(Mem_Address), 32'h0);
    exp_ld = 32'h0;
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
    repeat (4) @(negedge Clock);
    chk("midrst_no_restart", 32'(Busy), 32'd0);

    b_run(1'b0, 2'd3, 1'b0, 16'h0020, 32'h0, 32'h11223344, "be_ld_word");
    b_run(1'b0, 2'd0, 1'b1, 16'h0050, 32'h0, 32'hFFFFFF80, "be_ld_byte_s");
    b_run(1'b1, 2'd1, 1'b0, 16'h0060, 32'h0000BEEF, 32'h0, "be_st_half");

    repeat (3) @(negedge Clock);
    chk("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
    chk("done_queue_empty", 32'(exp_done.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
